// File: rtl/muldiv_pkg.sv
// Shared definitions for the M-extension issue unit: funct3 codes, FSM states,
// AB_status bit positions and operand-signedness helpers.
package muldiv_pkg;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_BUSY  = 2'd2,
        ST_DRAIN = 2'd3
    } state_e;

    // AB_status = {Bm1, B0, B1, Am1, A0, A1}
    localparam int AB_A1  = 0;
    localparam int AB_A0  = 1;
    localparam int AB_AM1 = 2;
    localparam int AB_B1  = 3;
    localparam int AB_B0  = 4;
    localparam int AB_BM1 = 5;
    localparam int AB_W   = 6;

    function automatic logic a_is_signed(input logic [2:0] f3);
        return f3 inside {F3_MUL, F3_MULH, F3_MULHSU, F3_DIV, F3_REM};
    endfunction

    function automatic logic b_is_signed(input logic [2:0] f3);
        return f3 inside {F3_MUL, F3_MULH, F3_DIV, F3_REM};
    endfunction

endpackage

// File: rtl/muldiv_issue_if.sv
// Bundle of pipeline-side and controller-side signals around the muldiv issue unit.
// master = the issue unit, slave = the surrounding pipeline and muldiv controller.
interface muldiv_issue_if #(
    parameter int XLEN = 32
);
    logic            ex_valid;
    logic            ex_is_muldiv;
    logic [2:0]      ex_funct3;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic            flush;
    logic            muldiv_done;
    logic [XLEN-1:0] muldiv_result;

    logic            start;
    logic            muldiv_sel;
    logic [1:0]      op_mul;
    logic            op_div1;
    logic [XLEN-1:0] A;
    logic [XLEN-1:0] B;
    logic [XLEN-1:0] A_2C;
    logic [XLEN-1:0] B_2C;
    logic [5:0]      AB_status;
    logic            stall;
    logic            wb_valid;
    logic [XLEN-1:0] wb_result;
    logic            timeout_err;

    modport master (
        input  ex_valid, ex_is_muldiv, ex_funct3, rs1, rs2, flush,
               muldiv_done, muldiv_result,
        output start, muldiv_sel, op_mul, op_div1, A, B, A_2C, B_2C,
               AB_status, stall, wb_valid, wb_result, timeout_err
    );

    modport slave (
        output ex_valid, ex_is_muldiv, ex_funct3, rs1, rs2, flush,
               muldiv_done, muldiv_result,
        input  start, muldiv_sel, op_mul, op_div1, A, B, A_2C, B_2C,
               AB_status, stall, wb_valid, wb_result, timeout_err
    );

endinterface

// File: rtl/muldiv_operand_classify.sv
// Combinational operand classifier: zero/one/minus-one flags and two's-complement
// negations of A and B, with the minus-one flags gated by operand signedness.
module muldiv_operand_classify
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic            a_signed_i,
    input  logic            b_signed_i,
    output logic [AB_W-1:0] ab_status_o,
    output logic [XLEN-1:0] a_2c_o,
    output logic [XLEN-1:0] b_2c_o
);

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        ab_status_o         = '0;
        ab_status_o[AB_A1]  = (a_i == XLEN'(1));
        ab_status_o[AB_A0]  = (a_i == '0);
        ab_status_o[AB_AM1] = a_signed_i & (a_i == '1);
        ab_status_o[AB_B1]  = (b_i == XLEN'(1));
        ab_status_o[AB_B0]  = (b_i == '0);
        ab_status_o[AB_BM1] = b_signed_i & (b_i == '1);
    end

    // Most-negative value negates to itself; the controller handles that case.
    assign a_2c_o = ~a_i + XLEN'(1);
    assign b_2c_o = ~b_i + XLEN'(1);

endmodule

// File: rtl/muldiv_issue.sv
// EX-stage initiator of the muldiv start/done handshake: latches and classifies
// operands, stalls the pipe, returns the result, and drains cleanly on flush.
// Optional feature: define MULDIV_RESULT_CACHE_EN for a one-entry last-result cache.
module muldiv_issue
    import muldiv_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int DONE_TIMEOUT = 0
) (
    input  logic          clk,
    input  logic          reset,
    muldiv_issue_if.master bus
);

    state_e            state_q, state_d;
    logic              accept;
    logic              capture;
    logic              start;
    logic              stall;
    logic              waiting;
    logic              cache_hit;
    logic [XLEN-1:0]   cache_result;

    logic [XLEN-1:0]   a_q, b_q, a_2c_q, b_2c_q;
    logic [2:0]        funct3_q;
    logic [AB_W-1:0]   ab_status_q;
    logic              wb_valid_q;
    logic [XLEN-1:0]   wb_result_q;
    logic              timeout_err;

    logic [AB_W-1:0]   ab_status_d;
    logic [XLEN-1:0]   a_2c_d, b_2c_d;

    assign accept  = (state_q == ST_IDLE) & bus.ex_valid & bus.ex_is_muldiv & ~bus.flush;
    assign waiting = (state_q == ST_BUSY) | (state_q == ST_DRAIN);

    // Classify at accept time so the latched status is ready in the ISSUE cycle.
    muldiv_operand_classify #(.XLEN(XLEN)) u_classify (
        .a_i         (bus.rs1),
        .b_i         (bus.rs2),
        .a_signed_i  (a_is_signed(bus.ex_funct3)),
        .b_signed_i  (b_is_signed(bus.ex_funct3)),
        .ab_status_o (ab_status_d),
        .a_2c_o      (a_2c_d),
        .b_2c_o      (b_2c_d)
    );

    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state is updated with non-blocking assignments only.
        if (!reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (accept && !cache_hit) state_d = ST_ISSUE;
            ST_ISSUE: state_d = (bus.flush || bus.muldiv_done) ? ST_IDLE : ST_BUSY;
            ST_BUSY: begin
                if (bus.muldiv_done)  state_d = ST_IDLE;
                else if (bus.flush)   state_d = ST_DRAIN;
            end
            ST_DRAIN: if (bus.muldiv_done) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        start   = 1'b0;
        stall   = 1'b0;
        capture = 1'b0;
        unique case (state_q)
            ST_IDLE:  stall = accept;
            ST_ISSUE: begin
                start   = ~bus.flush;
                stall   = 1'b1;
                capture = bus.muldiv_done & ~bus.flush;
            end
            ST_BUSY: begin
                stall   = 1'b1;
                capture = bus.muldiv_done & ~bus.flush;
            end
            // The killed op is only being waited out; stall just for a younger muldiv op.
            ST_DRAIN: stall = bus.ex_valid & bus.ex_is_muldiv;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_q         <= '0;
            b_q         <= '0;
            a_2c_q      <= '0;
            b_2c_q      <= '0;
            funct3_q    <= '0;
            ab_status_q <= '0;
            wb_valid_q  <= 1'b0;
            wb_result_q <= '0;
        end else begin
            if (accept) begin
                a_q         <= bus.rs1;
                b_q         <= bus.rs2;
                a_2c_q      <= a_2c_d;
                b_2c_q      <= b_2c_d;
                funct3_q    <= bus.ex_funct3;
                ab_status_q <= ab_status_d;
            end
            wb_valid_q <= capture | cache_hit;
            if (capture)        wb_result_q <= bus.muldiv_result;
            else if (cache_hit) wb_result_q <= cache_result;
        end
    end

`ifdef MULDIV_RESULT_CACHE_EN
    logic            cache_valid_q;
    logic [XLEN-1:0] cache_a_q, cache_b_q, cache_res_q;
    logic [2:0]      cache_f3_q;

    assign cache_hit = accept & cache_valid_q & (bus.rs1 == cache_a_q)
                     & (bus.rs2 == cache_b_q) & (bus.ex_funct3 == cache_f3_q);
    assign cache_result = cache_res_q;

    // NOTE: only the valid bit is reset; the payload is never read while valid is low.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cache_valid_q <= 1'b0;
        else if (state_q == ST_BUSY && state_d == ST_DRAIN) cache_valid_q <= 1'b0;
        else if (capture) cache_valid_q <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (capture) begin
            cache_a_q   <= a_q;
            cache_b_q   <= b_q;
            cache_f3_q  <= funct3_q;
            cache_res_q <= bus.muldiv_result;
        end
    end
`else
    assign cache_hit    = 1'b0;
    assign cache_result = '0;
`endif

    generate
        if (DONE_TIMEOUT > 0) begin : g_wd
            localparam int WD_W = $clog2(DONE_TIMEOUT + 1);
            logic [WD_W-1:0] wd_cnt_q;
            logic            wd_err_q;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    wd_cnt_q <= '0;
                    wd_err_q <= 1'b0;
                end else begin
                    if (!waiting)                              wd_cnt_q <= '0;
                    else if (wd_cnt_q != WD_W'(DONE_TIMEOUT))  wd_cnt_q <= wd_cnt_q + WD_W'(1);
                    if (wd_cnt_q == WD_W'(DONE_TIMEOUT))       wd_err_q <= 1'b1;
                end
            end
            assign timeout_err = wd_err_q;
        end else begin : g_no_wd
            assign timeout_err = 1'b0;
        end
    endgenerate

    assign bus.start       = start;
    assign bus.stall       = stall;
    assign bus.muldiv_sel  = funct3_q[2];
    assign bus.op_mul      = funct3_q[1:0];
    assign bus.op_div1     = funct3_q[1];
    assign bus.A           = a_q;
    assign bus.B           = b_q;
    assign bus.A_2C        = a_2c_q;
    assign bus.B_2C        = b_2c_q;
    assign bus.AB_status   = ab_status_q;
    assign bus.wb_valid    = wb_valid_q;
    assign bus.wb_result   = wb_result_q;
    assign bus.timeout_err = timeout_err;

endmodule

// File: tb/tb_muldiv_issue.sv
// Directed bench for muldiv_issue: the bench plays both pipeline and muldiv controller.
module tb_muldiv_issue;
    import muldiv_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    muldiv_issue_if #(.XLEN(32)) bus ();

    muldiv_issue #(.XLEN(32), .DONE_TIMEOUT(24)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic drive_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        bus.ex_valid     = 1'b1;
        bus.ex_is_muldiv = 1'b1;
        bus.ex_funct3    = f3;
        bus.rs1          = a;
        bus.rs2          = b;
    endtask

    task automatic drop_op();
        bus.ex_valid     = 1'b0;
        bus.ex_is_muldiv = 1'b0;
    endtask

    // Accept, then controller answers in the start cycle; wb_valid two cycles after accept.
    task automatic fast_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] res, input logic [5:0] status,
                           input logic [31:0] a2c, input logic [31:0] b2c);
        logic [1:0] op_exp;
        op_exp = f3[1:0];
        drive_op(f3, a, b);
        settle();
        check({tag, ".acc_stall"}, 32'(bus.stall), 32'd1);
        next_cycle();
        drop_op();
        bus.muldiv_done   = 1'b1;
        bus.muldiv_result = res;
        settle();
        check({tag, ".start"},     32'(bus.start), 32'd1);
        check({tag, ".status"},    32'(bus.AB_status), 32'(status));
        check({tag, ".a2c"},       bus.A_2C, a2c);
        check({tag, ".b2c"},       bus.B_2C, b2c);
        check({tag, ".sel"},       32'(bus.muldiv_sel), 32'(f3[2]));
        check({tag, ".op"},        32'(bus.op_mul), 32'(op_exp));
        next_cycle();
        bus.muldiv_done = 1'b0;
        settle();
        check({tag, ".wb_valid"},  32'(bus.wb_valid), 32'd1);
        check({tag, ".wb_result"}, bus.wb_result, res);
        check({tag, ".stall_off"}, 32'(bus.stall), 32'd0);
        next_cycle();
    endtask

    initial begin
        drop_op();
        bus.ex_funct3     = 3'b000;
        bus.rs1           = '0;
        bus.rs2           = '0;
        bus.flush         = 1'b0;
        bus.muldiv_done   = 1'b0;
        bus.muldiv_result = '0;

        // Reset state
        #12;
        check("rst.start",     32'(bus.start), 32'd0);
        check("rst.stall",     32'(bus.stall), 32'd0);
        check("rst.wb_valid",  32'(bus.wb_valid), 32'd0);
        check("rst.wb_result", bus.wb_result, 32'd0);
        check("rst.A",         bus.A, 32'd0);
        check("rst.B",         bus.B, 32'd0);
        check("rst.status",    32'(bus.AB_status), 32'd0);
        check("rst.timeout",   32'(bus.timeout_err), 32'd0);
        #1 rst_n = 1'b1;
        next_cycle();

        // MUL 7*6, controller done three cycles after start
        drive_op(F3_MUL, 32'd7, 32'd6);
        settle();
        check("mul.stall_n", 32'(bus.stall), 32'd1);
        check("mul.start_n", 32'(bus.start), 32'd0);
        next_cycle();
        drop_op();
        settle();
        check("mul.start_n1", 32'(bus.start), 32'd1);
        check("mul.A",        bus.A, 32'd7);
        check("mul.B",        bus.B, 32'd6);
        check("mul.A2C",      bus.A_2C, 32'hFFFF_FFF9);
        check("mul.status",   32'(bus.AB_status), 32'd0);
        next_cycle();
        settle();
        check("mul.start_n2", 32'(bus.start), 32'd0);
        check("mul.stall_n2", 32'(bus.stall), 32'd1);
        next_cycle();
        settle();
        check("mul.stall_n3", 32'(bus.stall), 32'd1);
        next_cycle();
        bus.muldiv_done   = 1'b1;
        bus.muldiv_result = 32'd42;
        settle();
        check("mul.stall_n4", 32'(bus.stall), 32'd1);
        check("mul.wbv_n4",   32'(bus.wb_valid), 32'd0);
        next_cycle();
        bus.muldiv_done = 1'b0;
        settle();
        check("mul.wbv_n5",   32'(bus.wb_valid), 32'd1);
        check("mul.wbr_n5",   bus.wb_result, 32'd42);
        check("mul.stall_n5", 32'(bus.stall), 32'd0);
        next_cycle();
        settle();
        check("mul.wbv_n6",   32'(bus.wb_valid), 32'd0);
        next_cycle();

        // Fast-path ops covering each status flag and the negation wrap
        fast_op("div0",   F3_DIV,    32'h64, 32'h0, 32'hFFFF_FFFF, 6'b010000, 32'hFFFF_FF9C, 32'h0);
        fast_op("mulhsu", F3_MULHSU, 32'h1,  32'hFFFF_FFFF, 32'h0, 6'b000001, 32'hFFFF_FFFF, 32'h1);
        fast_op("rem",    F3_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 6'b100000, 32'h8000_0000, 32'h1);
        fast_op("divu",   F3_DIVU,   32'h0,  32'h1, 32'h0, 6'b001010, 32'h0, 32'hFFFF_FFFF);

        // MULHU (no Am1) then back-to-back MUL with the same operands (Am1 set)
        drive_op(F3_MULHU, 32'hFFFF_FFFF, 32'h1);
        next_cycle();
        drop_op();
        bus.muldiv_done   = 1'b1;
        bus.muldiv_result = 32'h0;
        settle();
        check("mulhu.status", 32'(bus.AB_status), 32'(6'b001000));
        next_cycle();
        bus.muldiv_done = 1'b0;
        drive_op(F3_MUL, 32'hFFFF_FFFF, 32'h1);
        settle();
        check("b2b.wbv",   32'(bus.wb_valid), 32'd1);
        check("b2b.stall", 32'(bus.stall), 32'd1);
        check("b2b.start", 32'(bus.start), 32'd0);
        next_cycle();
        drop_op();
        bus.muldiv_done   = 1'b1;
        bus.muldiv_result = 32'hFFFF_FFFF;
        settle();
        check("b2b.start1", 32'(bus.start), 32'd1);
        check("b2b.status", 32'(bus.AB_status), 32'(6'b001100));
        next_cycle();
        bus.muldiv_done = 1'b0;
        settle();
        check("b2b.wbr", bus.wb_result, 32'hFFFF_FFFF);
        next_cycle();

        // Flush in the accept cycle: not accepted
        drive_op(F3_DIV, 32'd9, 32'd3);
        bus.flush = 1'b1;
        settle();
        check("flacc.stall", 32'(bus.stall), 32'd0);
        next_cycle();
        bus.flush = 1'b0;
        drop_op();
        settle();
        check("flacc.start", 32'(bus.start), 32'd0);
        next_cycle();

        // Flush in ISSUE: start suppressed, back to IDLE, no writeback
        drive_op(F3_DIV, 32'd9, 32'd3);
        next_cycle();
        drop_op();
        bus.flush = 1'b1;
        settle();
        check("fliss.start", 32'(bus.start), 32'd0);
        next_cycle();
        bus.flush = 1'b0;
        settle();
        check("fliss.start1", 32'(bus.start), 32'd0);
        check("fliss.stall",  32'(bus.stall), 32'd0);
        check("fliss.wbv",    32'(bus.wb_valid), 32'd0);
        next_cycle();
        settle();
        check("fliss.wbv1",   32'(bus.wb_valid), 32'd0);
        next_cycle();

        // DIV in flight, flush at N+3, done at N+20; MUL waiting from N+5
        drive_op(F3_DIV, 32'd100, 32'd7);
        next_cycle();
        drop_op();
        settle();
        check("drn.start", 32'(bus.start), 32'd1);
        next_cycle();
        next_cycle();
        bus.flush = 1'b1;
        settle();
        check("drn.stall_n3", 32'(bus.stall), 32'd1);
        next_cycle();
        bus.flush = 1'b0;
        settle();
        check("drn.stall_n4", 32'(bus.stall), 32'd0);
        next_cycle();
        drive_op(F3_MUL, 32'd2, 32'd3);
        settle();
        check("drn.stall_n5", 32'(bus.stall), 32'd1);
        check("drn.start_n5", 32'(bus.start), 32'd0);
        for (int k = 6; k <= 19; k++) begin
            next_cycle();
            bus.flush = (k == 10);
            settle();
            check("drn.stall_wait", 32'(bus.stall), 32'd1);
            check("drn.start_wait", 32'(bus.start), 32'd0);
        end
        next_cycle();
        bus.flush         = 1'b0;
        bus.muldiv_done   = 1'b1;
        bus.muldiv_result = 32'hDEAD;
        settle();
        check("drn.stall_n20", 32'(bus.stall), 32'd1);
        next_cycle();
        bus.muldiv_done = 1'b0;
        settle();
        check("drn.wbv_n21",   32'(bus.wb_valid), 32'd0);
        check("drn.stall_n21", 32'(bus.stall), 32'd1);
        check("drn.start_n21", 32'(bus.start), 32'd0);
        check("drn.timeout",   32'(bus.timeout_err), 32'd0);
        next_cycle();
        drop_op();
        bus.muldiv_done   = 1'b1;
        bus.muldiv_result = 32'd6;
        settle();
        check("drn.start_n22", 32'(bus.start), 32'd1);
        check("drn.A_n22",     bus.A, 32'd2);
        next_cycle();
        bus.muldiv_done = 1'b0;
        settle();
        check("drn.wbv_n23",   32'(bus.wb_valid), 32'd1);
        check("drn.wbr_n23",   bus.wb_result, 32'd6);
        next_cycle();

`ifdef MULDIV_RESULT_CACHE_EN
        // Same MUL twice back-to-back: second one served from the cache
        drive_op(F3_MUL, 32'd3, 32'd5);
        next_cycle();
        drop_op();
        bus.muldiv_done   = 1'b1;
        bus.muldiv_result = 32'd15;
        settle();
        check("cache.start1", 32'(bus.start), 32'd1);
        next_cycle();
        bus.muldiv_done = 1'b0;
        drive_op(F3_MUL, 32'd3, 32'd5);
        settle();
        check("cache.wbv1", 32'(bus.wb_valid), 32'd1);
        next_cycle();
        drop_op();
        settle();
        check("cache.wbv2",   32'(bus.wb_valid), 32'd1);
        check("cache.wbr2",   bus.wb_result, 32'd15);
        check("cache.nostart", 32'(bus.start), 32'd0);
        next_cycle();
        settle();
        check("cache.nostart1", 32'(bus.start), 32'd0);
        next_cycle();
`endif

        // Watchdog: controller never answers
        drive_op(F3_MUL, 32'd9, 32'd9);
        next_cycle();
        drop_op();
        settle();
        check("wd.start", 32'(bus.start), 32'd1);
        repeat (10) next_cycle();
        settle();
        check("wd.early", 32'(bus.timeout_err), 32'd0);
        repeat (20) next_cycle();
        settle();
        check("wd.late", 32'(bus.timeout_err), 32'd1);
        next_cycle();
        bus.muldiv_done   = 1'b1;
        bus.muldiv_result = 32'd81;
        next_cycle();
        bus.muldiv_done = 1'b0;
        settle();
        check("wd.wbr",    bus.wb_result, 32'd81);
        check("wd.sticky", 32'(bus.timeout_err), 32'd1);
        next_cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
